// File: rtl/dmem_mmio_subsystem.sv
// Data-memory subsystem: synchronous word RAM, memory-mapped LED/switch/cycle/status registers,
// post-reset RAM clear sequencer that stalls the CPU, and flagging of unmapped accesses.
module dmem_mmio_subsystem #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [31:0] MMIO_BASE      = 32'h0000_F000,
    parameter int unsigned LED_WIDTH      = 16,
    parameter int unsigned SW_WIDTH       = 16,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [31:0]           address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q_dmem,
    input  logic [SW_WIDTH-1:0]   switches,
    output logic [LED_WIDTH-1:0]  leds,
    output logic                  cpu_stall,
    output logic                  bad_access
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    function automatic logic [31:0] to_cyc(input logic [DATA_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32 && i < int'(DATA_WIDTH); i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] from_cyc(input logic [31:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < 32 && i < int'(DATA_WIDTH); i++) r[i] = v[i];
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_WIDTH-1:0] q_dmem_q, q_dmem_d;
    logic [LED_WIDTH-1:0]  leds_q, leds_d;
    logic [31:0]           cyc_q, cyc_d;
    logic                  sticky_q, sticky_d;
    logic                  bad_q, bad_d;
    logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  run;
    logic [31:0]           mmio_off;
    logic                  mmio_hit, ram_hit;
    logic [1:0]            mmio_sel;
    logic [DATA_WIDTH-1:0] ram_rdata, mmio_rdata;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign run      = (state_q == ST_RUN);
    assign mmio_off = address_dmem - MMIO_BASE;
    assign mmio_hit = (mmio_off < 32'd4);
    assign mmio_sel = mmio_off[1:0];
    // MMIO takes priority where the two windows overlap.
    assign ram_hit  = !mmio_hit && (address_dmem[31:ADDR_WIDTH] == '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
            if (clr_idx_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
        end
    end

    // The clear sequencer owns the RAM write port while it runs.
    assign ram_we    = run ? (wren && ram_hit) : 1'b1;
    assign ram_waddr = run ? address_dmem[ADDR_WIDTH-1:0] : clr_idx_q;
    assign ram_wdata = run ? data : '0;
    assign ram_rdata = mem[address_dmem[ADDR_WIDTH-1:0]];

    always_ff @(posedge clock) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_sel)
            2'd0:    mmio_rdata[LED_WIDTH-1:0] = leds_q;
            2'd1:    mmio_rdata[SW_WIDTH-1:0]  = sw_sync_q;
            2'd2:    mmio_rdata                = from_cyc(cyc_q);
            default: mmio_rdata[0]             = sticky_q;
        endcase
    end

    always_comb begin
        q_dmem_d = '0;
        leds_d   = leds_q;
        cyc_d    = cyc_q;
        sticky_d = sticky_q;
        bad_d    = 1'b0;
        if (run) begin
            cyc_d = cyc_q + 32'd1;
            if (mmio_hit) begin
                q_dmem_d = mmio_rdata;
                if (wren) begin
                    case (mmio_sel)
                        2'd0:    leds_d   = data[LED_WIDTH-1:0];
                        2'd2:    cyc_d    = to_cyc(data);
                        2'd3:    sticky_d = 1'b0;
                        default: ;
                    endcase
                end
            end else if (ram_hit) begin
                q_dmem_d = ram_rdata;
            end else begin
                bad_d    = 1'b1;
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_STATE;
            clr_idx_q <= '0;
            q_dmem_q  <= '0;
            leds_q    <= '0;
            cyc_q     <= '0;
            sticky_q  <= 1'b0;
            bad_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            q_dmem_q  <= q_dmem_d;
            leds_q    <= leds_d;
            cyc_q     <= cyc_d;
            sticky_q  <= sticky_d;
            bad_q     <= bad_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign q_dmem     = q_dmem_q;
    assign leds       = leds_q;
    assign bad_access = bad_q;
    assign cpu_stall  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_mmio_subsystem.sv
// Directed bench for dmem_mmio_subsystem with a 16-word RAM: clear sequencing, RAM, MMIO and bad-address paths.
module tb_dmem_mmio_subsystem;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic [15:0] switches;
    logic [15:0] leds;
    logic        cpu_stall;
    logic        bad_access;

    int vectors    = 0;
    int miscompares = 0;
    int n;

    dmem_mmio_subsystem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .MMIO_BASE(32'h0000_F000),
        .LED_WIDTH(16), .SW_WIDTH(16), .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
        .data(data), .q_dmem(q_dmem), .switches(switches), .leds(leds),
        .cpu_stall(cpu_stall), .bad_access(bad_access)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic w, input logic [31:0] a, input logic [31:0] d);
        wren = w;
        address_dmem = a;
        data = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_stall();
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("clear_len", n, 16);
    endtask

    initial begin
        reset = 1'b0;
        switches = '0;
        put(0, 0, 0);
        repeat (2) tick();
        chk("rst_q", q_dmem, 0);
        chk("rst_leds", {16'h0, leds}, 0);
        chk("rst_bad", {31'h0, bad_access}, 0);
        chk("rst_stall", {31'h0, cpu_stall}, 1);

        reset = 1'b1;
        count_stall();
        chk("post_clear_q", q_dmem, 0);

        // RAM write, read-back, read-during-write returns old data
        put(1, 5, 32'h1234_5678); tick();
        put(0, 5, 0);             tick();
        chk("ram_rd", q_dmem, 32'h1234_5678);
        put(1, 5, 32'h0000_AAAA); tick();
        chk("ram_rdw_old", q_dmem, 32'h1234_5678);
        put(0, 5, 0);             tick();
        chk("ram_rd_new", q_dmem, 32'h0000_AAAA);

        // LED register
        put(1, 32'hF000, 32'h0001_ABCD); tick();
        chk("leds", {16'h0, leds}, 32'h0000_ABCD);
        put(0, 32'hF000, 0); tick();
        chk("led_rd", q_dmem, 32'h0000_ABCD);

        // Switch synchroniser and write-ignore
        put(0, 32'hF001, 0);
        switches = 16'h00F0;
        tick();
        chk("sw_early", q_dmem, 0);
        tick(); tick();
        chk("sw_rd", q_dmem, 32'h0000_00F0);
        put(1, 32'hF001, 32'hFFFF_FFFF); tick();
        chk("sw_wr_bad", {31'h0, bad_access}, 0);
        put(0, 32'hF001, 0); tick();
        chk("sw_rd2", q_dmem, 32'h0000_00F0);

        // Cycle counter load and wrap
        put(1, 32'hF002, 32'hFFFF_FFFE); tick();
        put(0, 32'hF002, 0); tick();
        chk("cyc0", q_dmem, 32'hFFFF_FFFE);
        tick();
        chk("cyc1", q_dmem, 32'hFFFF_FFFF);
        tick();
        chk("cyc2", q_dmem, 32'h0000_0000);

        // Unmapped access, sticky status and its clear
        put(0, 5, 0); tick();
        chk("pre_bad_q", q_dmem, 32'h0000_AAAA);
        put(0, 32'h0001_0000, 0); tick();
        chk("bad_pulse", {31'h0, bad_access}, 1);
        chk("bad_q", q_dmem, 0);
        put(0, 32'hF003, 0); tick();
        chk("bad_end", {31'h0, bad_access}, 0);
        chk("stat_set", q_dmem, 1);
        put(1, 32'hF003, 0); tick();
        put(0, 32'hF003, 0); tick();
        chk("stat_clr", q_dmem, 0);
        put(1, 32'h0001_0005, 32'h0000_0BAD); tick();
        chk("bad_wr_pulse", {31'h0, bad_access}, 1);
        put(0, 5, 0); tick();
        chk("bad_wr_ignored", q_dmem, 32'h0000_AAAA);

        // Fill RAM with a pattern so the clear is observable
        for (int i = 0; i < 16; i++) begin
            put(1, i, 32'h0000_DEAD);
            tick();
        end
        put(0, 9, 0); tick();
        chk("preload", q_dmem, 32'h0000_DEAD);

        // Asynchronous reset, then reset again part-way through the clear
        #2 reset = 1'b0;
        #1;
        chk("arst_leds", {16'h0, leds}, 0);
        chk("arst_q", q_dmem, 0);
        chk("arst_stall", {31'h0, cpu_stall}, 1);
        tick();
        reset = 1'b1;
        repeat (7) tick();
        chk("mid_clear_stall", {31'h0, cpu_stall}, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'h0, cpu_stall}, 1);
        tick();
        reset = 1'b1;
        count_stall();

        for (int i = 0; i < 16; i++) begin
            put(0, i, 0);
            tick();
            chk($sformatf("cleared_%0d", i), q_dmem, 0);
        end
        put(0, 32'hF000, 0); tick();
        chk("led_rd_after_rst", q_dmem, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
